pipe_final_adder: RTL and testbench

PIPE_FINAL_ADDER -- requirements
Module: pipe_final_adder

---
 rtl/pipe_final_adder_if.sv | 26 ++
 rtl/pipe_final_adder.sv | 80 ++++++++
 tb/tb_pipe_final_adder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_final_adder_if.sv
// Operand/result handshake bundle for pipe_final_adder.
// The slave modport is the adder's view; master is the producer/consumer side.
interface pipe_final_adder_if #(
    parameter int unsigned WIDTH = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out
    );
endinterface

// File: rtl/pipe_final_adder.sv
// Segmented ripple-carry adder/subtractor pipelined over STAGES segments of SEG bits;
// the whole pipe freezes while the output holds an unaccepted result.
module pipe_final_adder #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned STAGES = 2
) (
    input logic                clk,
    input logic                rst,
    pipe_final_adder_if.slave  bus
);
    localparam int unsigned SEG = WIDTH / STAGES;

    if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_final_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    typedef struct packed {
        logic             vld;
        logic             cy;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } stage_t;

    stage_t      src     [STAGES];
    stage_t      stage_d [STAGES];
    stage_t      stage_q [STAGES];
    logic        advance;
    logic        cy;
    logic        p;
    logic        g;
    int unsigned idx;

    assign advance       = !stage_q[STAGES-1].vld || bus.out_ready;
    assign bus.in_ready  = advance && !rst;
    assign bus.out_valid = stage_q[STAGES-1].vld;
    assign bus.sum       = stage_q[STAGES-1].s;
    assign bus.c_out     = stage_q[STAGES-1].cy;

    // Subtract is folded in up front: invert b and force the carry-in.
    always_comb begin
        src[0].vld = bus.in_valid;
        src[0].cy  = bus.sub | bus.c_in;
        src[0].a   = bus.a;
        src[0].b   = bus.sub ? ~bus.b : bus.b;
        src[0].s   = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src[k] = stage_q[k-1];
        end
    end

    always_comb begin
        cy  = 1'b0;
        p   = 1'b0;
        g   = 1'b0;
        idx = 0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            stage_d[k] = src[k];
            cy         = src[k].cy;
            for (int unsigned j = 0; j < SEG; j++) begin
                idx               = k * SEG + j;
                p                 = src[k].a[idx] ^ src[k].b[idx];
                g                 = src[k].a[idx] & src[k].b[idx];
                stage_d[k].s[idx] = p ^ cy;
                cy                = g | (p & cy);
            end
            stage_d[k].cy = cy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (advance) begin
            stage_q <= stage_d;
        end
    end
endmodule

// File: tb/tb_pipe_final_adder.sv
// Directed and randomized checks of pipe_final_adder against an arithmetic scoreboard.
module tb_pipe_final_adder;
    localparam int unsigned W = 10;
    localparam int unsigned S = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [W:0] q[$];

    pipe_final_adder_if #(.WIDTH(W)) bus ();

    pipe_final_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W:0] ref_res(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sb);
        logic [W-1:0] nb;
        nb = ~b;
        if (sb) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge with scoreboard bookkeeping for both handshakes.
    task automatic step();
        logic       acc, deq, hold, rr;
        logic [W:0] exp_in;
        logic [W:0] obs;
        #1;
        acc    = bus.in_valid && bus.in_ready;
        deq    = bus.out_valid && bus.out_ready;
        hold   = bus.out_valid && !bus.out_ready;
        obs    = {bus.c_out, bus.sum};
        exp_in = ref_res(bus.a, bus.b, bus.c_in, bus.sub);
        rr     = rst;
        @(posedge clk);
        #1;
        if (rr) begin
            q.delete();
        end else begin
            if (deq) begin
                chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    chk("sb_result", 32'(obs), 32'(q[0]));
                    void'(q.pop_front());
                end
            end
            if (hold && !rr) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                if (q.size() != 0) chk("hold_result", 32'({bus.c_out, bus.sum}), 32'(q[0]));
            end
            if (acc) q.push_back(exp_in);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sb);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = cin;
        bus.sub      = sb;
    endtask

    task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sb,
                          input logic [W-1:0] es, input logic ec);
        drive(1'b1, a, b, cin, sb);
        step();
        chk({tag, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_cout"}, 32'(bus.c_out), 32'(ec));
        step();
        chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 10'h155, 10'h0AA, 1'b1, 1'b0);

        // Reset behaviour
        step();
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.c_out), 32'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed single operations
        single("wrap", 10'h3FF, 10'h001, 1'b0, 1'b0, 10'h000, 1'b1);
        single("sub_borrow", 10'h005, 10'h007, 1'b1, 1'b1, 10'h3FE, 1'b0);
        single("seg_carry", 10'h01F, 10'h001, 1'b0, 1'b0, 10'h020, 1'b0);
        single("sub_noborrow", 10'h200, 10'h0FF, 1'b0, 1'b1, 10'h101, 1'b1);
        single("cin_add", 10'h3E0, 10'h01F, 1'b1, 1'b0, 10'h000, 1'b1);

        // Back-to-back throughput
        drive(1'b1, 10'd1, 10'd1, 1'b0, 1'b0);
        #1 chk("b2b_rdy0", 32'(bus.in_ready), 32'd1);
        step();
        drive(1'b1, 10'd2, 10'd2, 1'b0, 1'b0);
        #1 chk("b2b_rdy1", 32'(bus.in_ready), 32'd1);
        step();
        chk("b2b_out0", 32'({bus.out_valid, bus.sum}), 32'({1'b1, 10'h002}));
        drive(1'b1, 10'd3, 10'd3, 1'b0, 1'b0);
        #1 chk("b2b_rdy2", 32'(bus.in_ready), 32'd1);
        step();
        chk("b2b_out1", 32'({bus.out_valid, bus.sum}), 32'({1'b1, 10'h004}));
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        chk("b2b_out2", 32'({bus.out_valid, bus.sum}), 32'({1'b1, 10'h006}));
        step();
        chk("b2b_empty", 32'(q.size()), 32'd0);

        // Fill the pipe against a stalled consumer
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        chk("full_depth", 32'(q.size()), 32'(S));
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 10) begin
            step();
            n++;
        end
        chk("stall_drain", 32'(q.size()), 32'd0);

        // Reset with work in flight
        drive(1'b1, 10'h111, 10'h022, 1'b0, 1'b0);
        step();
        drive(1'b1, 10'h0F0, 10'h00F, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_sum", 32'(bus.sum), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_ghost", 32'(bus.out_valid), 32'd0);
        end

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                  1'($urandom), 1'($urandom));
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("rand_drain", 32'(q.size()), 32'd0);
        step();
        chk("rand_idle", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
